taiga_param_fifo: RTL

- Parametrised synchronous FIFO; next generation of the core's push/pop/valid/full queue structure.
- Generalised in width and depth, including non-power-of-two depths.
- Adds an occupancy count, a programmable almost-full flag, a synchronous flush and an optional registered-output mode.
- Used by fetch, load/store queue and writeback paths wherever buffering between a producer and a consumer is needed.

---
 rtl/taiga_param_fifo_if.sv | 21 ++
 rtl/taiga_param_fifo.sv | 115 +++++++++++
 2 files changed

// File: rtl/taiga_param_fifo_if.sv
// Handshake bundle for taiga_param_fifo.
//   master: producer/consumer side (drives push, data_in, pop)
//   slave : FIFO side (drives data_out, valid, full, almost_full, count)
interface taiga_param_fifo_if #(
  parameter int DATA_WIDTH = 42,
  parameter int DEPTH      = 4
);
  logic                           push;
  logic [DATA_WIDTH-1:0]          data_in;
  logic                           pop;
  logic [DATA_WIDTH-1:0]          data_out;
  logic                           valid;
  logic                           full;
  logic                           almost_full;
  logic [$clog2(DEPTH+1)-1:0]     count;

  modport master (output push, data_in, pop,
                  input  data_out, valid, full, almost_full, count);
  modport slave  (input  push, data_in, pop,
                  output data_out, valid, full, almost_full, count);
endinterface

// File: rtl/taiga_param_fifo.sv
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-full, synchronous flush and optional registered output.
//   clk   : core clock, rising edge
//   rst   : synchronous active-high reset
//   flush : synchronous clear of queue state (same effect as rst)
//   bus   : push/data_in/pop in; data_out/valid/full/almost_full/count out
module taiga_param_fifo #(
  parameter int DATA_WIDTH            = 42,
  parameter int DEPTH                 = 4,
  parameter int ALMOST_FULL_THRESHOLD = DEPTH - 1,
  parameter int REGISTERED_OUTPUT     = 0
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  taiga_param_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Data storage carries no reset so it can map onto distributed RAM.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_vld_q, out_vld_d;
  logic                  push_eff, pop_eff, mem_we, mem_re, mem_empty;
  logic                  full_w, valid_w;

  // Explicit compare so non-power-of-two depths wrap correctly; with
  // DEPTH=1 the compare is against 0 and the pointer stays at 0.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_w  = (count_q == CW'(DEPTH));
  assign valid_w = (REGISTERED_OUTPUT != 0) ? out_vld_q : (count_q != '0);

  always_comb begin
    push_eff  = bus.push & ~full_w;
    pop_eff   = bus.pop & valid_w;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    // In registered mode count includes the output register, so memory
    // is empty when count equals the register's occupancy bit.
    mem_empty = (count_q == CW'(out_vld_q));

    if (REGISTERED_OUTPUT == 0) begin
      mem_we = push_eff;
      mem_re = pop_eff;
    end else if (!out_vld_q) begin
      // Empty: a push bypasses memory straight into the output register.
      if (push_eff) begin
        out_d     = bus.data_in;
        out_vld_d = 1'b1;
      end
    end else if (pop_eff) begin
      if (!mem_empty) begin
        out_d  = mem_q[rd_ptr_q];
        mem_re = 1'b1;
        mem_we = push_eff;
      end else if (push_eff) begin
        out_d = bus.data_in;
      end else begin
        out_vld_d = 1'b0;
      end
    end else begin
      mem_we = push_eff;
    end

    if (mem_we) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (mem_re) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CW'(push_eff) - CW'(pop_eff);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && mem_we) mem_q[wr_ptr_q] <= bus.data_in;
  end

  // Protocol checks; violating requests are dropped by the handshake logic.
  always_ff @(posedge clk) begin
    assert (ALMOST_FULL_THRESHOLD >= 1) else $error("almost-full threshold below 1");
    if (!rst && !flush) begin
      assert (!(bus.push && full_w)) else $warning("push while full ignored");
      assert (!(bus.pop && !valid_w)) else $warning("pop while empty ignored");
    end
  end

  assign bus.data_out    = (REGISTERED_OUTPUT != 0) ? out_q : mem_q[rd_ptr_q];
  assign bus.valid       = valid_w;
  assign bus.full        = full_w;
  assign bus.almost_full = (count_q >= CW'(ALMOST_FULL_THRESHOLD));
  assign bus.count       = count_q;
endmodule
